// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the IF/ID/EX/MEM/WB pipeline.
// Arbitrates memory-busy, taken-jump and load-use hazards.
// Optional perf counters: define HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pc_jump_en,
    input  logic                  mem_busy,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    output logic                  pc_pause,
    output logic                  ifid_pause,
    output logic                  idex_pause,
    output logic                  exmem_pause,
    output logic                  ifid_clear,
    output logic                  idex_clear,
    output logic                  memwb_clear,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_t     state_r, state_next_s;
    state_t     ret_state_r, ret_state_next_s;
    state_t     eff_state_s;
    logic [3:0] flush_left_r, flush_left_next_s;
    logic       load_use_s;

    logic pc_pause_s, ifid_pause_s, idex_pause_s, exmem_pause_s;
    logic ifid_clear_s, idex_clear_s, memwb_clear_s;

    // State, return-state and flush countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            ret_state_r  <= ST_RUN;
            flush_left_r <= 4'd0;
        end else begin
            state_r      <= state_next_s;
            ret_state_r  <= ret_state_next_s;
            flush_left_r <= flush_left_next_s;
        end
    end

    // Hazard arbitration: mem_busy > jump > flush tail > load-use
    always_comb begin
        state_next_s      = state_r;
        ret_state_next_s  = ret_state_r;
        flush_left_next_s = flush_left_r;
        pc_pause_s        = 1'b0;
        ifid_pause_s      = 1'b0;
        idex_pause_s      = 1'b0;
        exmem_pause_s     = 1'b0;
        ifid_clear_s      = 1'b0;
        idex_clear_s      = 1'b0;
        memwb_clear_s     = 1'b0;

        load_use_s = ex_mem_read &
                     ((id_rs1_used & (id_rs1 == ex_rd)) |
                      (id_rs2_used & (id_rs2 == ex_rd)));

        // Leaving MEM_WAIT resumes decoding as the interrupted state
        if (state_r == ST_MEM_WAIT) begin
            eff_state_s = ret_state_r;
        end else begin
            eff_state_s = state_r;
        end

        if (mem_busy) begin
            pc_pause_s    = 1'b1;
            ifid_pause_s  = 1'b1;
            idex_pause_s  = 1'b1;
            exmem_pause_s = 1'b1;
            memwb_clear_s = 1'b1;
            if (state_r != ST_MEM_WAIT) begin
                state_next_s     = ST_MEM_WAIT;
                ret_state_next_s = state_r;
            end else begin
                state_next_s     = ST_MEM_WAIT;
            end
        end else if (pc_jump_en) begin
            ifid_clear_s = 1'b1;
            idex_clear_s = 1'b1;
            if (MULTI_FLUSH) begin
                state_next_s      = ST_FLUSH;
                flush_left_next_s = FLUSH_RELOAD;
            end else begin
                state_next_s      = ST_RUN;
                flush_left_next_s = 4'd0;
            end
        end else if (eff_state_s == ST_FLUSH) begin
            // ID holds a killed slot here, so load-use is moot
            ifid_clear_s = 1'b1;
            if (flush_left_r <= 4'd1) begin
                state_next_s      = ST_RUN;
                flush_left_next_s = 4'd0;
            end else begin
                state_next_s      = ST_FLUSH;
                flush_left_next_s = flush_left_r - 4'd1;
            end
        end else if (load_use_s) begin
            pc_pause_s   = 1'b1;
            ifid_pause_s = 1'b1;
            idex_clear_s = 1'b1;
            state_next_s = ST_RUN;
        end else begin
            state_next_s = ST_RUN;
        end
    end

    // Reset forces every control low without waiting for a clock
    assign pc_pause    = pc_pause_s    & rst_n;
    assign ifid_pause  = ifid_pause_s  & rst_n;
    assign idex_pause  = idex_pause_s  & rst_n;
    assign exmem_pause = exmem_pause_s & rst_n;
    assign ifid_clear  = ifid_clear_s  & rst_n;
    assign idex_clear  = idex_clear_s  & rst_n;
    assign memwb_clear = memwb_clear_s & rst_n;

`ifdef HAZARD_PERF_EN
    logic jump_accept_s;
    assign jump_accept_s = rst_n & ~mem_busy & pc_jump_en;

    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    // Saturating stall and accepted-jump counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (pc_pause && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (jump_accept_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a
// priority/countdown reference model.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 3;
    localparam int FC = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_jump_en = 1'b0, mem_busy = 1'b0, ex_mem_read = 1'b0;
    logic [AW-1:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic          pc_pause, ifid_pause, idex_pause, exmem_pause;
    logic          ifid_clear, idex_clear, memwb_clear;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pc_jump_en(pc_jump_en), .mem_busy(mem_busy),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .pc_pause(pc_pause), .ifid_pause(ifid_pause), .idex_pause(idex_pause),
        .exmem_pause(exmem_pause), .ifid_clear(ifid_clear), .idex_clear(idex_clear),
        .memwb_clear(memwb_clear), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int m_rem = 0;     // remaining IF/ID-only kill cycles after a jump
    int m_stall = 0;
    int m_flush = 0;
    localparam int CMAX = (1 << CW) - 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctl_vec();
        return {pc_pause, ifid_pause, idex_pause, exmem_pause, ifid_clear, idex_clear, memwb_clear};
    endfunction

    task automatic check_counters(input string tag);
`ifdef HAZARD_PERF_EN
        check_val({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
        check_val({tag, "_flush"}, 32'(flush_cnt), 32'(m_flush));
`else
        check_val({tag, "_stall"}, 32'(stall_cnt), 32'd0);
        check_val({tag, "_flush"}, 32'(flush_cnt), 32'd0);
`endif
    endtask

    task automatic step(input string tag, input logic mb, input logic pj, input logic mr,
                        input logic [AW-1:0] rd, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic u1, input logic u2);
        logic [6:0] exp;
        logic       hz;
        @(posedge clk);
        #1;
        mem_busy = mb; pc_jump_en = pj; ex_mem_read = mr;
        ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
        #1;
        hz = mr && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
        if (mb)              exp = 7'b1111001;
        else if (pj)         exp = 7'b0000110;
        else if (m_rem > 0)  exp = 7'b0000100;
        else if (hz)         exp = 7'b1100010;
        else                 exp = 7'b0000000;
        check_val(tag, 32'(ctl_vec()), 32'(exp));
        check_counters(tag);
        if (exp[6] && m_stall < CMAX) m_stall++;
        if (!mb && pj) begin
            if (m_flush < CMAX) m_flush++;
            m_rem = FC - 1;
        end else if (!mb && m_rem > 0) begin
            m_rem--;
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_ctl", 32'(ctl_vec()), 32'd0);
        check_counters("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // idle after reset release
        for (int i = 0; i < 5; i++) idle("idle");

        // load-use stall, then unused source
        step("lu_hit", 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 3'd5, 1'b1, 1'b0);
        step("lu_off", 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 3'd5, 1'b0, 1'b0);
        step("lu_rs2", 1'b0, 1'b0, 1'b1, 3'd6, 3'd1, 3'd6, 1'b0, 1'b1);

        // single jump -> three kill cycles
        step("jmp", 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle("flush_tail");

        // mem_busy with held jump, then accepted jump
        for (int i = 0; i < 4; i++) step("mb_jmp", 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        step("mb_exit_jmp", 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle("mb_tail");

        // jump wins over load-use
        step("jmp_vs_lu", 1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 1'b1, 1'b1);
        // mem_busy interrupting a flush, flush resumes afterwards
        step("flush_mb", 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        step("flush_resume", 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle("resume_tail");

        // async reset mid-flush (flush_left == 2)
        step("jmp_pre_rst", 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        pc_jump_en = 1'b1;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_ctl", 32'(ctl_vec()), 32'd0);
        m_rem = 0; m_stall = 0; m_flush = 0;
        check_counters("rst_mid");
        pc_jump_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_rst");
        idle("post_rst");

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            step("rnd",
                 1'($urandom_range(0, 99) < 20),
                 1'($urandom_range(0, 99) < 15),
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
